// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT stream engine: FSM encoding, mode values and
// default geometry.
package ntt_pkg;

    localparam int DEFAULT_LOG_N  = 8;
    localparam int DEFAULT_DATA_W = 16;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_UNLOAD = 2'd3
    } state_e;

endpackage

// File: rtl/ntt_intt_top_reg.sv
// Functional stand-in for the transform core: one in-place sweep over the BRAM,
// reading word k on port B and writing its transform back on port A a cycle
// later. NTT rotates each word left by one bit, INTT rotates right, so INTT
// undoes NTT exactly. done_o pulses the cycle after the last write lands.
module ntt_intt_top_reg
    import ntt_pkg::*;
#(
    parameter int LOG_N  = DEFAULT_LOG_N,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    output logic              done_o,
    output logic [LOG_N-1:0]  addr_a_o,
    output logic [DATA_W-1:0] din_a_o,
    output logic              we_a_o,
    output logic [LOG_N-1:0]  addr_b_o,
    output logic [DATA_W-1:0] din_b_o,
    output logic              we_b_o,
    input  logic [DATA_W-1:0] dout_b_i
);

    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'((1 << LOG_N) - 1);

    logic             active_q;
    logic             wr_v_q;
    logic             done_q;
    logic             mode_q;
    logic [LOG_N-1:0] rd_idx_q;
    logic [LOG_N-1:0] wr_idx_q;

    // Read-address sweep plus a one-stage write-back pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            wr_v_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= MODE_NTT;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
        end else begin
            wr_v_q   <= active_q;
            wr_idx_q <= rd_idx_q;
            done_q   <= wr_v_q && (wr_idx_q == LAST_IDX);
            if (start_i) begin
                active_q <= 1'b1;
                rd_idx_q <= '0;
                mode_q   <= mode_i;
            end else if (active_q) begin
                rd_idx_q <= rd_idx_q + 1'b1;
                if (rd_idx_q == LAST_IDX) active_q <= 1'b0;
            end
        end
    end

    assign addr_b_o = rd_idx_q;
    assign din_b_o  = '0;
    assign we_b_o   = 1'b0;
    assign addr_a_o = wr_idx_q;
    assign we_a_o   = wr_v_q;
    assign din_a_o  = (mode_q == MODE_INTT) ? {dout_b_i[0], dout_b_i[DATA_W-1:1]}
                                            : {dout_b_i[DATA_W-2:0], dout_b_i[DATA_W-1]};
    assign done_o   = done_q;

endmodule

// File: rtl/ntt_tdp_bram.sv
// True-dual-port block RAM model, read-first, 1-cycle read latency on both ports.
// Contents are never reset.
module ntt_tdp_bram #(
    parameter int LOG_N  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic [LOG_N-1:0]  addr_a_i,
    input  logic [DATA_W-1:0] din_a_i,
    input  logic              we_a_i,
    output logic [DATA_W-1:0] dout_a_o,
    input  logic [LOG_N-1:0]  addr_b_i,
    input  logic [DATA_W-1:0] din_b_i,
    input  logic              we_b_i,
    output logic [DATA_W-1:0] dout_b_o
);

    logic [DATA_W-1:0] mem_q [1 << LOG_N];

    // Both ports write and read in one process; port B wins a same-address write.
    always_ff @(posedge clk_i) begin
        if (we_a_i) mem_q[addr_a_i] <= din_a_i;
        if (we_b_i) mem_q[addr_b_i] <= din_b_i;
        dout_a_o <= mem_q[addr_a_i];
        dout_b_o <= mem_q[addr_b_i];
    end

endmodule

// File: rtl/ntt_unload_fifo.sv
// Two-entry output FIFO for the unload stream. A read issued on the BRAM in
// cycle t returns data in cycle t+1, which is pushed unconditionally, so reads
// are only issued while a slot is guaranteed for the returning word.
module ntt_unload_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              rd_issue_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              can_issue_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic              inflight_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;
    logic [2:0]        credit_used;

    assign push      = inflight_q;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];
    assign pop       = m_valid_o && m_ready_i;

    // Occupancy is taken after this cycle's pop so a steady m_ready sustains
    // one beat per cycle without a third entry.
    assign credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign can_issue_o = (credit_used < 3'd2);

    // Pointer, occupancy and in-flight tracking; flush drops everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            inflight_q <= rd_issue_i;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Data storage, written as the BRAM word returns.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem_q[wr_ptr_q] <= rd_data_i;
    end

endmodule

// File: rtl/ntt_stream_engine.sv
// Streaming wrapper around the NTT/INTT core: host load stream into BRAM,
// automatic core launch, backpressured unload stream, in-place re-run, abort.
//
// Handshakes: a beat moves on a rising edge where valid and ready are both
// high; valid never waits on ready, and m_valid/m_data hold steady until taken.
module ntt_stream_engine
    import ntt_pkg::*;
#(
    parameter int LOG_N  = DEFAULT_LOG_N,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              start_inplace,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'((1 << LOG_N) - 1);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [LOG_N-1:0] load_cnt_q, load_cnt_d;
    logic [LOG_N:0]   rd_cnt_q, rd_cnt_d;
    logic [LOG_N-1:0] out_cnt_q, out_cnt_d;
    logic             core_start_q, core_start_d;
    logic             done_q, done_d;
    logic             abort_q;

    logic              load_fire, rd_issue, fifo_can_issue, m_fire;
    logic [LOG_N-1:0]  bram_addr_a, bram_addr_b, core_addr_a, core_addr_b;
    logic [DATA_W-1:0] bram_din_a, bram_din_b, bram_dout_a, bram_dout_b;
    logic [DATA_W-1:0] core_din_a, core_din_b;
    logic              bram_we_a, bram_we_b, core_we_a, core_we_b;
    logic              core_done, core_rst;

    assign m_fire = m_valid && m_ready;

    // Next-state, counter updates and load/unload handshake controls.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        load_cnt_d = load_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        done_d     = 1'b0;
        s_ready    = 1'b0;
        rd_issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = !start_inplace;
                if (start_inplace) begin
                    mode_d  = mode;
                    state_d = ST_RUN;
                end else if (s_valid) begin
                    mode_d     = mode;
                    load_cnt_d = load_cnt_q + 1'b1;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LAST_IDX) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) state_d = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                rd_issue = fifo_can_issue && !rd_cnt_q[LOG_N];
                if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
                if (m_fire) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == LAST_IDX) begin
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                        rd_cnt_d  = '0;
                        out_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything decided above.
        if (abort) begin
            state_d    = ST_IDLE;
            mode_d     = mode_q;
            load_cnt_d = '0;
            rd_cnt_d   = '0;
            out_cnt_d  = '0;
            done_d     = 1'b0;
            s_ready    = 1'b0;
            rd_issue   = 1'b0;
        end
        load_fire = s_valid && s_ready;
    end

    assign core_start_d = (state_d == ST_RUN) && (state_q != ST_RUN);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_NTT;
            load_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            out_cnt_q    <= '0;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            load_cnt_q   <= load_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            out_cnt_q    <= out_cnt_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            abort_q      <= abort;
        end
    end

    // BRAM port ownership follows the registered state: the core owns both
    // ports in RUN, otherwise port A serves load writes or unload reads.
    always_comb begin
        if (state_q == ST_RUN) begin
            bram_addr_a = core_addr_a;
            bram_din_a  = core_din_a;
            bram_we_a   = core_we_a;
            bram_addr_b = core_addr_b;
            bram_din_b  = core_din_b;
            bram_we_b   = core_we_b;
        end else begin
            bram_addr_a = (state_q == ST_UNLOAD) ? rd_cnt_q[LOG_N-1:0] : load_cnt_q;
            bram_din_a  = s_data;
            bram_we_a   = load_fire;
            bram_addr_b = '0;
            bram_din_b  = '0;
            bram_we_b   = 1'b0;
        end
    end

    assign core_rst = rst || abort_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign m_last   = m_valid && (out_cnt_q == LAST_IDX);

    ntt_tdp_bram #(.LOG_N(LOG_N), .DATA_W(DATA_W)) u_bram (
        .clk_i    (clk),
        .addr_a_i (bram_addr_a),
        .din_a_i  (bram_din_a),
        .we_a_i   (bram_we_a),
        .dout_a_o (bram_dout_a),
        .addr_b_i (bram_addr_b),
        .din_b_i  (bram_din_b),
        .we_b_i   (bram_we_b),
        .dout_b_o (bram_dout_b)
    );

    ntt_intt_top_reg #(.LOG_N(LOG_N), .DATA_W(DATA_W)) u_core (
        .clk_i    (clk),
        .rst_i    (core_rst),
        .start_i  (core_start_q),
        .mode_i   (mode_q),
        .done_o   (core_done),
        .addr_a_o (core_addr_a),
        .din_a_o  (core_din_a),
        .we_a_o   (core_we_a),
        .addr_b_o (core_addr_b),
        .din_b_o  (core_din_b),
        .we_b_o   (core_we_b),
        .dout_b_i (bram_dout_b)
    );

    ntt_unload_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (abort),
        .rd_issue_i  (rd_issue),
        .rd_data_i   (bram_dout_a),
        .can_issue_o (fifo_can_issue),
        .m_valid_o   (m_valid),
        .m_data_o    (m_data),
        .m_ready_i   (m_ready)
    );

endmodule

// File: tb/tb_ntt_stream_engine.sv
// Bench for ntt_stream_engine: streams vectors in, lets the core run, and
// compares every unloaded word against an array model of the BRAM contents.
module tb_ntt_stream_engine;
    import ntt_pkg::*;

    localparam int LOG_N  = 8;
    localparam int DATA_W = 16;
    localparam int N      = 1 << LOG_N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mode = 1'b0;
    logic              start_inplace = 1'b0;
    logic              abort = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready = 1'b0;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_core_start = 0;
    int n_bad_wr = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] vec[N];
    int                model_mem[N];

    // clock
    always #5 clk = ~clk;

    ntt_stream_engine #(.LOG_N(LOG_N), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .start_inplace (start_inplace),
        .abort         (abort),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .busy          (busy),
        .done          (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // event counters sampled mid-cycle
    always @(negedge clk) begin
        if (done) n_done++;
        if (dut.core_start_q) n_core_start++;
        if (!s_valid && dut.bram_we_a && dut.state_q != ST_RUN) n_bad_wr++;
    end

    // core transform: NTT doubles modulo 2^16 with the top bit wrapped round,
    // INTT halves with the bottom bit wrapped to the top
    function automatic int xform(input int x, input bit md);
        if (md == 1'b0) return (x * 2 + x / 32768) % 65536;
        return x / 2 + (x % 2) * 32768;
    endfunction

    task automatic model_run(input bit md);
        for (int i = 0; i < N; i++) model_mem[i] = xform(model_mem[i], md);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(DATA_W'(model_mem[i]));
    endtask

    task automatic load_vec(input bit throttle, input bit md, input int n_beats);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < n_beats && cyc < 4 * N) begin
            s_valid = throttle ? (cyc % 2 == 0) : 1'b1;
            s_data  = vec[i];
            mode    = (i == 0) ? md : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s_valid && s_ready) begin
                model_mem[i] = int'(vec[i]);
                i++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        check_eq("load_beats", i, n_beats);
        if (n_beats == N) begin
            @(negedge clk);
            check_eq("core_start_after_last", dut.core_start_q, 1);
            check_eq("run_s_ready", s_ready, 0);
            check_eq("run_busy", busy, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_inplace(input bit md);
        start_inplace = 1'b1;
        mode          = md;
        s_valid       = 1'b1;
        s_data        = 16'hDEAD;
        @(negedge clk);
        check_eq("inplace_s_ready", s_ready, 0);
        @(posedge clk); #1;
        start_inplace = 1'b0;
        s_valid       = 1'b0;
        mode          = ~md;
        @(negedge clk);
        check_eq("inplace_core_start", dut.core_start_q, 1);
        check_eq("inplace_busy", busy, 1);
        @(posedge clk); #1;
    endtask

    // pat 0: always ready, 1: ready 1,0,0,1 repeating, 2: random
    task automatic unload_vec(input int pat, input int n_beats);
        int beats, cyc, unl_cyc, val_cyc, last_cyc;
        bit stalled;
        logic [DATA_W-1:0] held, e;
        beats = 0; cyc = 0; unl_cyc = -1; val_cyc = -1; last_cyc = -1;
        stalled = 1'b0; held = '0;
        while (beats < n_beats && cyc < 8 * N) begin
            case (pat)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (unl_cyc < 0 && dut.state_q == ST_UNLOAD) unl_cyc = cyc;
            if (val_cyc < 0 && m_valid) val_cyc = cyc;
            if (stalled) begin
                check_eq("hold_valid", m_valid, 1);
                check_eq("hold_data", m_data, held);
            end
            stalled = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 'x;
                check_eq("m_data", m_data, e);
                check_eq("m_last", m_last, (beats == N - 1));
                beats++;
                last_cyc = cyc;
            end else if (m_valid) begin
                stalled = 1'b1;
                held = m_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
        check_eq("unload_beats", beats, n_beats);
        check_eq("first_valid_latency", val_cyc - unl_cyc, 2);
        if (pat == 0) check_eq("throughput", last_cyc - val_cyc, n_beats - 1);
        if (n_beats == N) begin
            @(negedge clk);
            check_eq("done_pulse", done, 1);
            check_eq("done_busy_low", busy, 0);
            check_eq("done_m_valid_low", m_valid, 0);
            @(posedge clk); #1;
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int d0;
        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // zero vector
        for (int i = 0; i < N; i++) vec[i] = '0;
        load_vec(1'b0, MODE_NTT, N);
        model_run(MODE_NTT);
        unload_vec(0, N);

        // ramp round trip, second pass under backpressure
        for (int i = 0; i < N; i++) vec[i] = DATA_W'(i);
        load_vec(1'b0, MODE_NTT, N);
        model_run(MODE_NTT);
        unload_vec(0, N);
        run_inplace(MODE_INTT);
        model_run(MODE_INTT);
        for (int i = 0; i < N; i++) check_eq("roundtrip_model", DATA_W'(model_mem[i]), DATA_W'(i));
        unload_vec(1, N);

        // throttled load of random data, INTT first
        for (int i = 0; i < N; i++) vec[i] = DATA_W'($urandom);
        load_vec(1'b1, MODE_INTT, N);
        model_run(MODE_INTT);
        unload_vec(2, N);

        // abort during load, then a fresh load
        for (int i = 0; i < N; i++) vec[i] = DATA_W'($urandom);
        load_vec(1'b0, MODE_NTT, 100);
        d0 = n_done;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_s_ready", s_ready, 1);
        check_eq("abort_m_valid", m_valid, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_eq("abort_no_done", n_done - d0, 0);
        for (int i = 0; i < N; i++) vec[i] = DATA_W'($urandom);
        load_vec(1'b0, MODE_NTT, N);
        model_run(MODE_NTT);
        unload_vec(0, N);

        // reset mid-unload, then in-place rerun on the retained contents
        for (int i = 0; i < N; i++) vec[i] = DATA_W'($urandom);
        load_vec(1'b0, MODE_NTT, N);
        model_run(MODE_NTT);
        unload_vec(0, 50);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_m_valid", m_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_s_ready", s_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_inplace(MODE_INTT);
        model_run(MODE_INTT);
        unload_vec(2, N);

        // totals
        check_eq("done_pulses", n_done, 6);
        check_eq("core_starts", n_core_start, 7);
        check_eq("writes_without_valid", n_bad_wr, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
